// File: rtl/seg_reg_buf.sv
// Pipeline segment register: a DEPTH-entry in-order buffer with valid/ready on both sides,
// whole-stage flush, and (for DEPTH>=2) a registered in_ready that isolates upstream from out_ready.
module seg_reg_buf #(
   parameter int W       = 32,
   parameter int DEPTH   = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // With DEPTH==1 the pointer is one bit but pinned at 0; the spare slot is never written or read.
   localparam int NSLOT = 1 << PTR_W;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [W-1:0]     mem_q [NSLOT];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;

   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? mem_q[rd_q] : '0;
   assign count     = cnt_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
         if (pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
         if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
         else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload storage is deliberately not reset; out_data is masked by out_valid instead.
   always_ff @(posedge clock) begin
      if (push && !flush) mem_q[wr_q] <= in_data;
   end

   generate
      if (DEPTH == 1) begin : g_pass
         assign in_ready = !out_valid || out_ready;
      end else begin : g_reg
         localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
         logic rdy_q;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) rdy_q <= 1'b0;
            else        rdy_q <= (cnt_d < FULL);
         end
         assign in_ready = rdy_q;
      end
   endgenerate

endmodule

// File: tb/tb_seg_reg_buf.sv
// Bench for seg_reg_buf: directed scenarios on DEPTH=1/2/4 instances plus a randomised
// DEPTH=8 run against a queue model.
module tb_seg_reg_buf;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int checks = 0;
   int fails  = 0;

   logic fl1, iv1, ir1, ov1, or1;  logic [31:0] id1, od1;  logic [0:0] c1;
   logic fl2, iv2, ir2, ov2, or2;  logic [31:0] id2, od2;  logic [1:0] c2;
   logic fl4, iv4, ir4, ov4, or4;  logic [31:0] id4, od4;  logic [2:0] c4;
   logic fl8, iv8, ir8, ov8, or8;  logic [7:0]  id8, od8;  logic [3:0] c8;

   seg_reg_buf #(.W(32), .DEPTH(1)) u_d1 (.clock(clock), .reset(reset), .flush(fl1),
      .in_valid(iv1), .in_ready(ir1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
      .out_data(od1), .count(c1));
   seg_reg_buf #(.W(32), .DEPTH(2)) u_d2 (.clock(clock), .reset(reset), .flush(fl2),
      .in_valid(iv2), .in_ready(ir2), .in_data(id2), .out_valid(ov2), .out_ready(or2),
      .out_data(od2), .count(c2));
   seg_reg_buf #(.W(32), .DEPTH(4)) u_d4 (.clock(clock), .reset(reset), .flush(fl4),
      .in_valid(iv4), .in_ready(ir4), .in_data(id4), .out_valid(ov4), .out_ready(or4),
      .out_data(od4), .count(c4));
   seg_reg_buf #(.W(8), .DEPTH(8)) u_d8 (.clock(clock), .reset(reset), .flush(fl8),
      .in_valid(iv8), .in_ready(ir8), .in_data(id8), .out_valid(ov8), .out_ready(or8),
      .out_data(od8), .count(c8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [31:0] q4[$];
   logic [7:0]  q8[$];
   logic [7:0]  seq;
   logic        mrdy, mpush, mpop;
   int          ecnt[5] = '{4, 3, 3, 2, 1};

   initial begin
      {fl1, iv1, or1, fl2, iv2, or2, fl4, iv4, or4, fl8, iv8, or8} = '0;
      id1 = '0; id2 = '0; id4 = '0; id8 = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("rst d1 count", 32'(c1), 0);
      chk("rst d1 out_valid", 32'(ov1), 0);
      chk("rst d1 out_data", od1, 0);
      chk("rst d1 in_ready", 32'(ir1), 1);
      chk("rst d4 in_ready", 32'(ir4), 0);
      chk("rst d4 count", 32'(c4), 0);
      chk("rst d2 in_ready", 32'(ir2), 0);
      #9 reset = 1'b1;
      step();
      chk("rel d4 in_ready", 32'(ir4), 1);
      chk("rel d2 in_ready", 32'(ir2), 1);

      // DEPTH=1 pass-through
      or1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         iv1 = 1'b1;
         id1 = 32'hA5A5_0001 + 32'(i);
         #1;
         chk("d1 in_ready", 32'(ir1), 1);
         step();
         chk("d1 out_valid", 32'(ov1), 1);
         chk("d1 out_data", od1, 32'hA5A5_0001 + 32'(i));
         chk("d1 count", 32'(c1), 1);
      end
      iv1 = 1'b0;
      step();
      chk("d1 drained", 32'(ov1), 0);
      chk("d1 drained count", 32'(c1), 0);

      // DEPTH=4 fill and stall
      or4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iv4 = 1'b1;
         id4 = 32'h10 + 32'(i);
         #1;
         chk("d4 fill in_ready", 32'(ir4), 1);
         step();
      end
      chk("d4 full count", 32'(c4), 4);
      chk("d4 full in_ready", 32'(ir4), 0);
      chk("d4 full head", od4, 32'h10);
      id4 = 32'h14;
      step();
      chk("d4 refused count", 32'(c4), 4);
      or4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("d4 drain valid", 32'(ov4), 1);
         chk("d4 drain data", od4, 32'h10 + 32'(k));
         chk("d4 drain count", 32'(c4), 32'(ecnt[k]));
         if (k == 0) chk("d4 full ignores out_ready", 32'(ir4), 0);
         if (k == 1) chk("d4 in_ready after pop", 32'(ir4), 1);
         step();
         if (k == 1) iv4 = 1'b0;
      end
      #1;
      chk("d4 empty valid", 32'(ov4), 0);
      chk("d4 empty data", od4, 0);
      chk("d4 empty count", 32'(c4), 0);

      // DEPTH=4 wrap-around at count=2
      or4 = 1'b0;
      iv4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         id4 = 32'h100 + 32'(i);
         step();
         q4.push_back(32'h100 + 32'(i));
      end
      or4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         id4 = 32'h102 + 32'(i);
         #1;
         chk("wrap in_ready", 32'(ir4), 1);
         chk("wrap data", od4, q4[0]);
         chk("wrap count", 32'(c4), 2);
         step();
         void'(q4.pop_front());
         q4.push_back(32'h102 + 32'(i));
      end
      iv4 = 1'b0;
      while (q4.size() != 0) begin
         #1;
         chk("wrap drain data", od4, q4[0]);
         step();
         void'(q4.pop_front());
      end
      chk("wrap drain count", 32'(c4), 0);

      // Flush with simultaneous push and pop
      or4 = 1'b0;
      iv4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id4 = 32'h200 + 32'(i);
         step();
      end
      iv4 = 1'b0;
      #1;
      chk("flush pre count", 32'(c4), 3);
      fl4 = 1'b1; iv4 = 1'b1; id4 = 32'h2FF; or4 = 1'b1;
      #1;
      chk("flush pre in_ready", 32'(ir4), 1);
      step();
      fl4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
      #1;
      chk("flush count", 32'(c4), 0);
      chk("flush valid", 32'(ov4), 0);
      chk("flush data", od4, 0);
      chk("flush in_ready", 32'(ir4), 1);
      fl4 = 1'b1; iv4 = 1'b1; id4 = 32'h2EE;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("held flush count", 32'(c4), 0);
         chk("held flush valid", 32'(ov4), 0);
      end
      fl4 = 1'b0; id4 = 32'h300;
      step();
      iv4 = 1'b0;
      #1;
      chk("post flush data", od4, 32'h300);
      chk("post flush count", 32'(c4), 1);
      or4 = 1'b1;
      step();
      or4 = 1'b0;
      chk("post flush drain", 32'(c4), 0);

      // Asynchronous reset mid-stream on DEPTH=2
      iv2 = 1'b1; id2 = 32'h400;
      step();
      id2 = 32'h401;
      step();
      iv2 = 1'b0;
      #1;
      chk("d2 full count", 32'(c2), 2);
      chk("d2 full in_ready", 32'(ir2), 0);
      chk("d2 full head", od2, 32'h400);
      #1 reset = 1'b0;
      #1;
      chk("async rst valid", 32'(ov2), 0);
      chk("async rst count", 32'(c2), 0);
      chk("async rst in_ready", 32'(ir2), 0);
      chk("async rst data", od2, 0);
      #2 reset = 1'b1;
      step();
      chk("d2 rel in_ready", 32'(ir2), 1);
      chk("d2 rel valid", 32'(ov2), 0);
      iv2 = 1'b1; id2 = 32'h500;
      step();
      iv2 = 1'b0;
      #1;
      chk("d2 first push valid", 32'(ov2), 1);
      chk("d2 first push data", od2, 32'h500);
      chk("d2 first push count", 32'(c2), 1);
      or2 = 1'b1;
      step();
      or2 = 1'b0;

      // DEPTH=8 randomised backpressure against a queue model
      seq  = '0;
      mrdy = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (!iv8) iv8 = ($urandom_range(0, 3) != 0);
         id8 = seq;
         or8 = ($urandom_range(0, 99) < ((cyc < 100) ? 30 : 70));
         fl8 = ($urandom_range(0, 39) == 0);
         #1;
         chk("rnd count", 32'(c8), 32'(q8.size()));
         chk("rnd valid", 32'(ov8), 32'(q8.size() != 0));
         chk("rnd data", 32'(od8), (q8.size() != 0) ? 32'(q8[0]) : 32'h0);
         chk("rnd in_ready", 32'(ir8), 32'(mrdy));
         mpush = iv8 && mrdy;
         mpop  = (q8.size() != 0) && or8;
         step();
         if (fl8) q8.delete();
         else begin
            if (mpop)  void'(q8.pop_front());
            if (mpush) q8.push_back(seq);
         end
         if (mpush) begin
            seq++;
            iv8 = 1'b0;
         end
         mrdy = (q8.size() < 8);
      end
      fl8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seg_reg_buf.md
Name: seg_reg_buf

Overview:
- Parametrised pipeline segment register that replaces the fixed single-entry inter-stage registers between pipeline stages (ID->EX, EX->MEM, ...).
- Carries an opaque W-bit payload. Stages pack and unpack their control and data fields around it.
- Holds up to DEPTH entries with a valid/ready handshake on both sides and a whole-stage flush.
- For DEPTH>=2, in_ready is a registered, full-based signal, so the upstream ready path is cut from out_ready.

Parameters:
W, 32, payload width in bits (>=1)
DEPTH, 2, number of entries; power of two, >=1
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush of all entries (branch/exception redirect)
in_valid  in  1  upstream has a payload
in_ready  out  1  this block accepts a payload this cycle
in_data  in  W  upstream payload
out_valid  out  1  oldest entry is valid
out_ready  in  1  downstream accepts the oldest entry this cycle
out_data  out  W  oldest entry payload
count  out  CNT_W  current number of valid entries

Behaviour:
- Reset (reset==0, asynchronous):
  - count=0, pointers=0, out_valid=0, out_data=0.
  - For DEPTH>=2, in_ready=0 while reset is asserted and 1 from the first clock edge after deassertion. For DEPTH==1, in_ready=1.
  - Storage array is not reset.
- Push and pop:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - push writes in_data at the write pointer. pop advances the read pointer.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count increments on push only and decrements on pop only. It is unchanged on simultaneous push+pop.
- Latency:
  - Minimum 1 cycle: a payload pushed at edge N appears on out_data with out_valid=1 after edge N.
  - There is no combinational path from in_data or in_valid to any output.
- Outputs:
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr] when out_valid, else 0. The value is held stable while out_valid && !out_ready.
- in_ready, DEPTH==1 mode (exact pass-through stage):
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Simultaneous push+pop when full is allowed and replaces the entry; count stays at 1.
- in_ready, DEPTH>=2 mode:
  - in_ready is a flop set to 1 when the next count < DEPTH.
  - When count==DEPTH, a push is refused even if out_ready=1 in that cycle. in_ready returns to 1 the cycle after the pop.
  - When count==DEPTH-1, simultaneous push+pop keeps in_ready=1.
- Empty:
  - pop cannot occur (out_valid=0).
  - A push into an empty buffer is visible on the next cycle only; there is no bypass.
- Flush (synchronous, highest priority after reset):
  - At the edge where flush==1: count<=0 and rd_ptr<=wr_ptr<=0. Any push or pop in that cycle is discarded.
  - out_valid=0 from the next cycle.
  - For DEPTH>=2, in_ready=1 from the next cycle.
  - A flush asserted for multiple cycles holds the buffer empty.
- Upstream rule: once in_valid is asserted, in_data must not change until the push is accepted. The block does not check this rule.
- Reset asserted mid-operation: all entries are lost immediately, asynchronously. No output glitches to a stale payload with out_valid=1.

Test Plan:
- DEPTH=1 passthrough: push 0xA5A5_0001..0xA5A5_0004 with out_ready=1 every cycle -> one output per cycle in order, count never exceeds 1, in_ready constant 1.
- DEPTH=4 fill/stall: out_ready=0, push 5 payloads 0x10..0x14 -> first 4 accepted, count=4, in_ready=0 from the cycle after the 4th push, 0x14 held on in_data; then out_ready=1 -> outputs 0x10,0x11,0x12,0x13,0x14 in order, in_ready back to 1 one cycle after the first pop.
- DEPTH=4 wrap-around: 10 cycles of simultaneous push/pop at count=2 -> write pointer wraps at least twice, outputs strictly in push order, count stays 2.
- Flush with simultaneous push+pop: DEPTH=4, count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1, and the flushed and pushed payloads never appear.
- Async reset mid-stream: DEPTH=2, count=2, drive reset low between clock edges -> out_valid=0, count=0 and in_ready=0 immediately; after release, the first push appears one cycle later.
- W=8, DEPTH=8 backpressure randomisation: 200 random in_valid/out_ready cycles -> scoreboard shows no loss, no duplication, in-order delivery, count matches the model each cycle.
